// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the multi-core data-memory arbiter: FSM encoding,
// default interface widths and the index-width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;

  // A single core still needs a one-bit index so the port widths stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin pick: the first requester at or after ptr,
// wrapping modulo NUM_CORES, returned as a one-hot grant and an index.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int IDX_W     = idx_width(DEF_NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  always_comb begin
    int k;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      k = (int'(ptr) + i) % NUM_CORES;
      if (!valid && req[k]) begin
        valid    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one registered single-port data memory among
// NUM_CORES cores; reads walk IDLE-ACCESS-WAIT-RESP, writes skip WAIT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_wren,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_end,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           dram_addr,
  output logic [DATA_W-1:0]           dram_data,
  output logic                        dram_wren,
  input  logic [DATA_W-1:0]           dram_out,
  output logic                        all_done
);

  localparam int               IDX_W    = idx_width(NUM_CORES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  arb_state_t           state, state_d;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]     grant_idx, grant_idx_d;
  logic [NUM_CORES-1:0] grant_oh, grant_oh_d;
  logic                 grant_wren, grant_wren_d;
  logic [NUM_CORES-1:0] ack_d;
  logic [DATA_W-1:0]    rdata_d;
  logic [ADDR_W-1:0]    dram_addr_d;
  logic [DATA_W-1:0]    dram_data_d;
  logic                 dram_wren_d;

  logic [NUM_CORES-1:0] pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  rr_pick #(
    .NUM_CORES(NUM_CORES),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req  (core_req),
    .ptr  (rr_ptr),
    .grant(pick_oh),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  // Every output is registered, so each state computes the values the
  // outputs must carry during the following state.
  always_comb begin
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    grant_idx_d  = grant_idx;
    grant_oh_d   = grant_oh;
    grant_wren_d = grant_wren;
    ack_d        = '0;
    rdata_d      = core_rdata;
    dram_addr_d  = dram_addr;
    dram_data_d  = dram_data;
    dram_wren_d  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d      = ACCESS;
          grant_idx_d  = pick_idx;
          grant_oh_d   = pick_oh;
          grant_wren_d = core_wren[pick_idx];
          dram_addr_d  = core_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          dram_data_d  = core_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          dram_wren_d  = core_wren[pick_idx];
        end
      end
      ACCESS: begin
        if (grant_wren) begin
          state_d = RESP;
          ack_d   = grant_oh;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = RESP;
        rdata_d = dram_out;
        ack_d   = grant_oh;
      end
      RESP: begin
        state_d  = IDLE;
        rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset mid-transaction simply drops the latched grant; the core re-requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      grant_oh   <= '0;
      grant_wren <= 1'b0;
      core_ack   <= '0;
      core_rdata <= '0;
      dram_addr  <= '0;
      dram_data  <= '0;
      dram_wren  <= 1'b0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      grant_idx  <= grant_idx_d;
      grant_oh   <= grant_oh_d;
      grant_wren <= grant_wren_d;
      core_ack   <= ack_d;
      core_rdata <= rdata_d;
      dram_addr  <= dram_addr_d;
      dram_data  <= dram_data_d;
      dram_wren  <= dram_wren_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      all_done <= 1'b0;
    end else begin
      all_done <= &core_end;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a registered memory model answers the shared
// port, and a queue of expected acks is matched against each ack pulse.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  core_req;
  logic [3:0]  core_wren;
  logic [63:0] core_addr;
  logic [63:0] core_wdata;
  logic [3:0]  core_end;
  logic [3:0]  core_ack;
  logic [15:0] core_rdata;
  logic [15:0] dram_addr;
  logic [15:0] dram_data;
  logic        dram_wren;
  logic [15:0] dram_out;
  logic        all_done;

  typedef struct {
    logic [3:0]  ack;
    logic [15:0] rdata;
    bit          chk_rdata;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          failed = 0;
  int          wren_count = 0;
  logic [15:0] mem[int];

  mem_arbiter #(
    .NUM_CORES(4),
    .ADDR_W   (16),
    .DATA_W   (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .core_req  (core_req),
    .core_wren (core_wren),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_end  (core_end),
    .core_ack  (core_ack),
    .core_rdata(core_rdata),
    .dram_addr (dram_addr),
    .dram_data (dram_data),
    .dram_wren (dram_wren),
    .dram_out  (dram_out),
    .all_done  (all_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] mem_pattern(input logic [15:0] a);
    return 16'hA5A5 ^ a;
  endfunction

  // Registered single-port memory: read data appears one cycle after the address.
  always @(posedge clock) begin
    dram_out <= mem.exists(int'(dram_addr)) ? mem[int'(dram_addr)] : mem_pattern(dram_addr);
    if (dram_wren === 1'b1) mem[int'(dram_addr)] = dram_data;
  end

  always @(negedge clock) begin
    if (dram_wren === 1'b1) wren_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input int core, input logic req, input logic wren,
                               input logic [15:0] addr, input logic [15:0] wdata);
    core_req[core]             = req;
    core_wren[core]            = wren;
    core_addr[core*16 +: 16]   = addr;
    core_wdata[core*16 +: 16]  = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void expectAck(input logic [3:0] a, input logic [15:0] d, input bit c);
    sb.push_back('{a, d, c});
  endfunction

  // Waits (bounded) for the next ack pulse and compares it with the queue head.
  task automatic checkAck(input string tag, input int exp_ticks);
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      tick();
      n++;
      if (core_ack !== 4'b0000) seen = 1'b1;
    end
    e = sb.pop_front();
    checkOutput({tag, "_ack"}, {28'd0, core_ack}, {28'd0, e.ack});
    checkOutput({tag, "_latency"}, n, exp_ticks);
    if (e.chk_rdata) checkOutput({tag, "_rdata"}, {16'd0, core_rdata}, {16'd0, e.rdata});
  endtask

  initial begin
    int          wren_before;
    logic [3:0]  ack_seen;

    // Reset must dominate live requests and a full core_end vector.
    reset      = 1'b1;
    core_req   = 4'b1111;
    core_wren  = 4'b1111;
    core_addr  = 64'h0001_0002_0003_0004;
    core_wdata = 64'h1111_2222_3333_4444;
    core_end   = 4'b1111;
    tick();
    tick();
    checkOutput("rst_ack", {28'd0, core_ack}, 32'd0);
    checkOutput("rst_rdata", {16'd0, core_rdata}, 32'd0);
    checkOutput("rst_dram_wren", {31'd0, dram_wren}, 32'd0);
    checkOutput("rst_dram_addr", {16'd0, dram_addr}, 32'd0);
    checkOutput("rst_dram_data", {16'd0, dram_data}, 32'd0);
    checkOutput("rst_all_done", {31'd0, all_done}, 32'd0);
    core_req  = 4'b0000;
    core_wren = 4'b0000;
    core_end  = 4'b0000;
    reset     = 1'b0;
    tick();

    // Core1 writes 0xBEEF to 0x0010.
    applyStimulus(1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    expectAck(4'b0010, 16'h0000, 1'b0);
    wren_before = wren_count;
    tick();
    checkOutput("wr_dram_wren", {31'd0, dram_wren}, 32'd1);
    checkOutput("wr_dram_addr", {16'd0, dram_addr}, 32'h0010);
    checkOutput("wr_dram_data", {16'd0, dram_data}, 32'hBEEF);
    checkOutput("wr_no_early_ack", {28'd0, core_ack}, 32'd0);
    checkAck("wr", 1);
    checkOutput("wr_pulses", wren_count - wren_before, 32'd1);
    applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("wr_ack_clear", {28'd0, core_ack}, 32'd0);

    // Core2 reads back 0x0010.
    applyStimulus(2, 1'b1, 1'b0, 16'h0010, 16'h0000);
    expectAck(4'b0100, 16'hBEEF, 1'b1);
    wren_before = wren_count;
    checkAck("rd", 3);
    checkOutput("rd_no_wren", wren_count - wren_before, 32'd0);
    applyStimulus(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Core3 changes its address after the grant; the transaction must not notice.
    applyStimulus(3, 1'b1, 1'b0, 16'h0005, 16'h0000);
    expectAck(4'b1000, mem_pattern(16'h0005), 1'b1);
    tick();
    applyStimulus(3, 1'b1, 1'b0, 16'h0009, 16'h0000);
    checkOutput("hold_addr_access", {16'd0, dram_addr}, 32'h0005);
    tick();
    checkOutput("hold_addr_wait", {16'd0, dram_addr}, 32'h0005);
    checkAck("hold", 1);
    applyStimulus(3, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // All four cores read continuously from reset: grants rotate 0,1,2,3,0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 1'b0, 16'h0020 + 16'(i), 16'h0000);
    for (int i = 0; i < 5; i++) expectAck(4'b0001 << (i % 4), mem_pattern(16'h0020 + 16'(i % 4)), 1'b1);
    checkAck("rot0", 3);
    for (int i = 1; i < 5; i++) checkAck($sformatf("rot%0d", i), 4);
    core_req = 4'b0000;
    tick();

    // Core0 write interrupted by reset in ACCESS; pointer was 1 beforehand.
    applyStimulus(0, 1'b1, 1'b1, 16'h0030, 16'h1234);
    tick();
    checkOutput("abort_wren_access", {31'd0, dram_wren}, 32'd1);
    reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    reset = 1'b0;
    wren_before = wren_count;
    checkOutput("abort_wren", {31'd0, dram_wren}, 32'd0);
    checkOutput("abort_ack", {28'd0, core_ack}, 32'd0);
    checkOutput("abort_addr", {16'd0, dram_addr}, 32'd0);
    ack_seen = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      ack_seen |= core_ack;
    end
    checkOutput("abort_no_late_ack", {28'd0, ack_seen}, 32'd0);
    checkOutput("abort_no_late_wren", wren_count - wren_before, 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    applyStimulus(1, 1'b1, 1'b0, 16'h0041, 16'h0000);
    expectAck(4'b0001, mem_pattern(16'h0040), 1'b1);
    checkAck("abort_ptr", 3);
    core_req = 4'b0000;
    tick();

    // all_done is the registered AND of core_end.
    core_end = 4'b0111;
    tick();
    checkOutput("done_partial", {31'd0, all_done}, 32'd0);
    core_end = 4'b1111;
    tick();
    checkOutput("done_full", {31'd0, all_done}, 32'd1);
    core_end = 4'b1110;
    tick();
    checkOutput("done_drop", {31'd0, all_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4, number of requesting cores.
REQ-002 Parameter ADDR_W, default 16, data-memory address width.
REQ-003 Parameter DATA_W, default 16, data word width.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 core_req  input  NUM_CORES  per-core access request, held high until that core's ack.
REQ-007 core_wren  input  NUM_CORES  per-core access type: 1 = write, 0 = read.
REQ-008 core_addr  input  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 core_wdata  input  NUM_CORES*DATA_W  per-core write data, packed the same way.
REQ-010 core_end  input  NUM_CORES  per-core end_process flag.
REQ-011 core_ack  output  NUM_CORES  one-cycle, one-hot completion pulse to the granted core.
REQ-012 core_rdata  output  DATA_W  read data returned to all cores; valid in the ack cycle.
REQ-013 dram_addr  output  ADDR_W  shared data-memory address.
REQ-014 dram_data  output  DATA_W  shared data-memory write data.
REQ-015 dram_wren  output  1  shared data-memory write enable.
REQ-016 dram_out  input  DATA_W  data-memory read port; registered, valid one cycle after the address is presented.
REQ-017 all_done  output  1  high when every core_end bit is high.

Function
REQ-018 The FSM SHALL have four states: IDLE, ACCESS, WAIT, RESP.
REQ-019 IDLE: if any core_req is high, grant the first requesting core at or after rr_ptr (modulo NUM_CORES), latch its wren/addr/wdata and index, go to ACCESS; otherwise stay in IDLE.
REQ-020 ACCESS, one cycle: drive dram_addr and dram_data from the latched values, with dram_wren = latched wren; go to WAIT for a read, RESP for a write.
REQ-021 WAIT, one cycle: hold dram_addr, with dram_wren=0; capture dram_out into the rdata register at the end of the cycle; go to RESP.
REQ-022 RESP, one cycle: assert core_ack[granted] alone; core_rdata = captured read data, or unchanged for a write; set rr_ptr = granted+1 (wrap from NUM_CORES-1 to 0); go to IDLE.
REQ-023 Latency from grant (IDLE cycle) to ack: write 3 cycles, read 4 cycles.
REQ-024 dram_wren SHALL be high only in ACCESS of a write transaction; never more than one cycle per transaction.
REQ-025 Requests are sampled only in IDLE; changes to req/addr/wdata after the grant have no effect on the transaction in flight.
REQ-026 A core whose req falls before being granted is simply not granted; no error.
REQ-027 The cycle after RESP is always IDLE, so a core holding req continuously is re-granted only after all other requesters at or after rr_ptr.
REQ-028 With all NUM_CORES requesting continuously, grants SHALL rotate 0,1,2,3,0,... (starvation-free).
REQ-029 all_done SHALL be the registered AND of core_end, updated every cycle and independent of FSM state.
REQ-030 core_ack SHALL be all zeros outside RESP.

Reset
REQ-031 On reset, all of the following SHALL be cleared: state = IDLE, rr_ptr = 0, core_ack = 0, core_rdata = 0, dram_wren = 0, dram_addr = 0, dram_data = 0, all_done = 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction: no ack and no further dram_wren; the core re-requests.
REQ-033 Reset dominates every other input in the same cycle.

Structure
REQ-034 State encodings (IDLE=0, ACCESS=1, WAIT=2, RESP=3) and default widths SHALL live in the shared package.
REQ-035 A sub-module rr_pick (combinational round-robin priority pick: req vector + pointer -> one-hot grant + index) SHALL be used.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Core1 writes 0xBEEF to 0x0010 -> dram_wren high for 1 cycle with addr 0x0010, data 0xBEEF; core_ack=0010 three cycles after grant.
REQ-038 Core2 reads 0x0010 (memory holds 0xBEEF) -> core_ack=0100 four cycles after grant, with core_rdata=0xBEEF.
REQ-039 All four cores request reads continuously from reset -> ack order 0,1,2,3,0; no ack overlap.
REQ-040 Core0 write in flight; reset asserted in ACCESS -> dram_wren=0 next cycle, no ack, state IDLE, rr_ptr=0.
REQ-041 core_end driven 0111 then 1111 -> all_done 0, then 1 one cycle after the 1111 edge.
REQ-042 Core3 changes addr from 0x0005 to 0x0009 after grant -> dram_addr stays 0x0005 for the transaction.
